// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, screen bounds and colour constants.
// Imported by the sync generator, its interface and every scene renderer.
package vga_pkg;

    // Counter width shared by pixel_x / pixel_y and the renderers that decode them.
    localparam int unsigned CNT_W = 10;

    // Default 640x480 @ 60 Hz timing, 25 MHz pixel clock derived from 100 MHz.
    localparam int unsigned VGA_CLK_DIV   = 4;
    localparam int unsigned VGA_H_DISPLAY = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_DISPLAY = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Visible screen bounds, inclusive.
    localparam logic [CNT_W-1:0] SCREEN_X_MIN = CNT_W'(0);
    localparam logic [CNT_W-1:0] SCREEN_X_MAX = CNT_W'(VGA_H_DISPLAY - 1);
    localparam logic [CNT_W-1:0] SCREEN_Y_MIN = CNT_W'(0);
    localparam logic [CNT_W-1:0] SCREEN_Y_MAX = CNT_W'(VGA_V_DISPLAY - 1);

    // 12-bit RGB (4:4:4) colours used by the renderers.
    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hfff;
    localparam logic [11:0] GRAY  = 12'h888;
    localparam logic [11:0] RED   = 12'hf00;

    // Inclusive rectangle hit test; renderers combine it with video_on.
    function automatic logic in_window(input logic [CNT_W-1:0] x,
                                       input logic [CNT_W-1:0] y,
                                       input logic [CNT_W-1:0] x_lo,
                                       input logic [CNT_W-1:0] x_hi,
                                       input logic [CNT_W-1:0] y_lo,
                                       input logic [CNT_W-1:0] y_hi);
        return (x >= x_lo) && (x <= x_hi) && (y >= y_lo) && (y <= y_hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if: the pixel position / sync bus driven by vga_sync and consumed by
// renderers, the RGB mux and the connector.
// Optional: VGA_SYNC_FRAME_CNT_EN adds the 8-bit frame_cnt signal.
interface vga_sync_if;
    import vga_pkg::*;

    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             p_tick;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0]       frame_cnt;
`endif

    modport master (
        output hsync,
        output vsync,
        output video_on,
        output p_tick,
        output pixel_x,
        output pixel_y,
`ifdef VGA_SYNC_FRAME_CNT_EN
        output frame_cnt,
`endif
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input video_on,
        input p_tick,
        input pixel_x,
        input pixel_y,
`ifdef VGA_SYNC_FRAME_CNT_EN
        input frame_cnt,
`endif
        input frame_start
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock by CLK_DIV and flags the last
// system clock of every pixel period.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    // Keep at least one bit so CLK_DIV == 1 still elaborates (p_tick stuck high).
    localparam int unsigned          CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    // Wrap by compare-and-clear so non-power-of-two dividers work.
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_ONE;
        if (div_cnt_q == CNT_MAX) begin
            div_cnt_d = '0;
        end
    end

    // Divider state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign p_tick = (div_cnt_q == CNT_MAX);

endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator. Produces pixel_x/pixel_y counters, active-low
// hsync/vsync, video_on and a frame_start marker, all registered so they change
// together on the edge that ends a p_tick cycle.
// Optional: define VGA_SYNC_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic p_tick;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             frame_start_q, frame_start_d;
    logic             h_end;
    logic             v_end;

    assign h_end = (h_cnt_q == H_LAST);
    assign v_end = (v_cnt_q == V_LAST);

    // Next position: advance x on each tick, advance y when x wraps.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick) begin
            if (h_end) begin
                h_cnt_d = '0;
                v_cnt_d = v_end ? '0 : (v_cnt_q + CNT_ONE);
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
            end
        end
    end

    // Decode from the next position so the flags line up with the counters.
    always_comb begin
        hsync_d       = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
        vsync_d       = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
        video_on_d    = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    // Position and sync registers; reset parks at the last pixel of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_x     = h_cnt_q;
    assign vga.pixel_y     = v_cnt_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.frame_start = frame_start_q;
    assign vga.p_tick      = p_tick;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic       frame_wrap;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    assign frame_wrap = p_tick && h_end && v_end;

    // Count completed wraps to (0,0); the 8-bit add rolls 255 over to 0.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed bench for vga_sync. A full-size instance checks startup,
// one line and asynchronous reset; a shrunken-timing instance checks whole
// frames, a window renderer and (when enabled) the frame counter.
module tb_vga_sync;
    import vga_pkg::*;

    typedef struct {
        int div;
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
    } geo_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fs;
        logic       pt;
        logic [7:0] fc;
    } obs_t;

    // Small timing: 8 pixels x 6 lines, 2 clocks per pixel.
    localparam int S_DIV = 2;
    localparam int S_HD = 4, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int S_VD = 3, S_VF = 1, S_VS = 1, S_VB = 1;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vga_sync_if vga_a ();
    vga_sync_if vga_b ();

    vga_sync u_dut (
        .clk  (clk),
        .reset(rst_a),
        .vga  (vga_a.master)
    );

    vga_sync #(
        .CLK_DIV  (S_DIV),
        .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_small (
        .clk  (clk),
        .reset(rst_b),
        .vga  (vga_b.master)
    );

    // Window renderer on the small screen: x 2..5, y 1..3, gated by video_on.
    logic hit;
    assign hit = vga_b.video_on &&
                 in_window(vga_b.pixel_x, vga_b.pixel_y, 10'd2, 10'd5, 10'd1, 10'd3);

    function automatic int htot(input geo_t g);
        return g.hd + g.hf + g.hs + g.hb;
    endfunction

    function automatic int vtot(input geo_t g);
        return g.vd + g.vf + g.vs + g.vb;
    endfunction

    function automatic obs_t sample(input bit sel);
        obs_t o;
        o.fc = '0;
        if (sel) begin
            o.x = vga_b.pixel_x; o.y = vga_b.pixel_y; o.hs = vga_b.hsync;
            o.vs = vga_b.vsync; o.vo = vga_b.video_on; o.fs = vga_b.frame_start;
            o.pt = vga_b.p_tick;
`ifdef VGA_SYNC_FRAME_CNT_EN
            o.fc = vga_b.frame_cnt;
`endif
        end else begin
            o.x = vga_a.pixel_x; o.y = vga_a.pixel_y; o.hs = vga_a.hsync;
            o.vs = vga_a.vsync; o.vo = vga_a.video_on; o.fs = vga_a.frame_start;
            o.pt = vga_a.p_tick;
`ifdef VGA_SYNC_FRAME_CNT_EN
            o.fc = vga_a.frame_cnt;
`endif
        end
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected flags for position (ex,ey) computed straight from the timing table.
    task automatic check_pos(input string tag, input obs_t o, input geo_t g,
                             input int ex, input int ey);
        int hs0;
        int vs0;
        hs0 = g.hd + g.hf;
        vs0 = g.vd + g.vf;
        check_eq({tag, ".x"},  32'(o.x),  32'(ex));
        check_eq({tag, ".y"},  32'(o.y),  32'(ey));
        check_eq({tag, ".hs"}, 32'(o.hs), 32'(!(ex >= hs0 && ex < hs0 + g.hs)));
        check_eq({tag, ".vs"}, 32'(o.vs), 32'(!(ey >= vs0 && ey < vs0 + g.vs)));
        check_eq({tag, ".vo"}, 32'(o.vo), 32'(ex < g.hd && ey < g.vd));
        check_eq({tag, ".fs"}, 32'(o.fs), 32'(ex == 0 && ey == 0));
        check_eq({tag, ".pt"}, 32'(o.pt), 32'(g.div == 1));
    endtask

    task automatic check_reset(input string tag, input bit sel, input geo_t g);
        obs_t o;
        o = sample(sel);
        check_eq({tag, ".x"},  32'(o.x),  32'(htot(g) - 1));
        check_eq({tag, ".y"},  32'(o.y),  32'(vtot(g) - 1));
        check_eq({tag, ".hs"}, 32'(o.hs), 32'd1);
        check_eq({tag, ".vs"}, 32'(o.vs), 32'd1);
        check_eq({tag, ".vo"}, 32'(o.vo), 32'd0);
        check_eq({tag, ".fs"}, 32'(o.fs), 32'd0);
        check_eq({tag, ".pt"}, 32'(o.pt), 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check_eq({tag, ".fc"}, 32'(o.fc), 32'd0);
`endif
    endtask

    // Call right after reset release: counters hold until edge div, then (0,0).
    task automatic check_startup(input bit sel, input geo_t g);
        obs_t o;
        for (int e = 1; e < g.div; e++) begin
            @(posedge clk);
            #1;
            o = sample(sel);
            check_eq("start.x",    32'(o.x),  32'(htot(g) - 1));
            check_eq("start.tick", 32'(o.pt), 32'(e == g.div - 1));
        end
        @(posedge clk);
        #1;
        o = sample(sel);
        check_pos("first", o, g, 0, 0);
    endtask

    // Advance one pixel period; outputs must hold until the tick edge.
    task automatic step_pixel(input bit sel, input geo_t g, inout int ex,
                              inout int ey, output obs_t o);
        obs_t p;
        p = sample(sel);
        repeat (g.div - 1) @(posedge clk);
        #1;
        o = sample(sel);
        check_eq("hold.x",    32'(o.x),  32'(p.x));
        check_eq("hold.tick", 32'(o.pt), 32'd1);
        @(posedge clk);
        #1;
        ex++;
        if (ex == htot(g)) begin
            ex = 0;
            ey++;
            if (ey == vtot(g)) ey = 0;
        end
        o = sample(sel);
        check_pos("pix", o, g, ex, ey);
    endtask

    initial begin
        geo_t ga;
        geo_t gb;
        obs_t o;
        int   ex;
        int   ey;
        int   cnt;
        int   nfr;
        int   fr;
        int   last_fs;
        int   fs_n;
        int   yw;
        logic [9:0] py;
`ifdef VGA_SYNC_FRAME_CNT_EN
        int   k;
`endif
        ga = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        gb = '{S_DIV, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB};

        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_a", 1'b0, ga);
        check_reset("rst_b", 1'b1, gb);

        // Full-size startup, then one line plus a partial one.
        @(negedge clk);
        rst_a = 1'b0;
        check_startup(1'b0, ga);
        ex = 0; ey = 0; cnt = 0;
        for (int i = 0; i < 800; i++) begin
            step_pixel(1'b0, ga, ex, ey, o);
            if (o.hs == 1'b0) cnt++;
        end
        check_eq("line.hs_len", 32'(cnt), 32'd96);
        check_eq("line.y_wrap", 32'(o.y), 32'd1);
        for (int i = 0; i < 300; i++) step_pixel(1'b0, ga, ex, ey, o);
        check_eq("mid.x", 32'(o.x), 32'd300);

        // Asynchronous reset between edges, then resync.
        #3;
        rst_a = 1'b1;
        #1;
        check_reset("async", 1'b0, ga);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        check_startup(1'b0, ga);

        // Small-timing frames.
        @(negedge clk);
        rst_b = 1'b0;
        check_startup(1'b1, gb);
        fr = htot(gb) * vtot(gb);
`ifdef VGA_SYNC_FRAME_CNT_EN
        nfr = 256;
        k = 1;
        o = sample(1'b1);
        check_eq("fcnt.first", 32'(o.fc), 32'd1);
`else
        nfr = 2;
`endif
        ex = 0; ey = 0; cnt = 0; last_fs = 0; fs_n = 0; yw = 0;
        o = sample(1'b1);
        for (int i = 0; i < nfr * fr; i++) begin
            py = o.y;
            step_pixel(1'b1, gb, ex, ey, o);
            if (o.vs == 1'b0) cnt++;
            if (py == 10'(vtot(gb) - 1) && o.y == 10'd0) yw++;
            if (o.fs) begin
                fs_n++;
                check_eq("frame.gap", 32'(i + 1 - last_fs), 32'(fr));
                last_fs = i + 1;
            end
            check_eq("render", 32'(hit),
                     32'(ex >= 2 && ex <= 5 && ey >= 1 && ey <= 3 && ex < S_HD && ey < S_VD));
`ifdef VGA_SYNC_FRAME_CNT_EN
            if (ex == 0 && ey == 0) k++;
            check_eq("fcnt", 32'(o.fc), 32'(k % 256));
`endif
        end
        check_eq("frame.fs_cnt", 32'(fs_n), 32'(nfr));
        check_eq("frame.vs_len", 32'(cnt),  32'(nfr * S_VS * htot(gb)));
        check_eq("frame.y_wrap", 32'(yw),   32'(nfr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
